// File: rtl/mod_add_serial_if.sv
// mod_add_serial_if: operand/result handshake bundle for the serial modular adder.
// range_err exists only when MOD_ADD_RANGE_CHECK_EN is defined.
interface mod_add_serial_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] N;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
`ifdef MOD_ADD_RANGE_CHECK_EN
    logic             range_err;
`endif

    modport master (
        output in_valid, A, B, N, out_ready,
        input  in_ready, out_valid, R
`ifdef MOD_ADD_RANGE_CHECK_EN
        , input range_err
`endif
    );

    modport slave (
        input  in_valid, A, B, N, out_ready,
        output in_ready, out_valid, R
`ifdef MOD_ADD_RANGE_CHECK_EN
        , output range_err
`endif
    );
endinterface

// File: rtl/mod_add_serial.sv
// mod_add_serial: digit-serial R = (A + B) mod N, sum and trial-subtract chains in parallel.
// Optional operand range flag under MOD_ADD_RANGE_CHECK_EN.
module mod_add_serial #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mod_add_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic             bw_q, bw_d;
    logic [DIGIT:0]   sum_k;
    logic [DIGIT:0]   dif_k;
    logic [WIDTH-1:0] s_nx;
    logic [WIDTH-1:0] d_nx;

    assign sum_k = {1'b0, a_q[DIGIT-1:0]}
                 + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, c_q};
    assign dif_k = {1'b0, sum_k[DIGIT-1:0]}
                 - {1'b0, n_q[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, bw_q};

    // New digits enter at the MSB end so after NDIG shifts digit 0 sits at the LSB.
    assign s_nx = (s_q >> DIGIT)
                | (WIDTH'(sum_k[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign d_nx = (d_q >> DIGIT)
                | (WIDTH'(dif_k[DIGIT-1:0]) << (WIDTH - DIGIT));

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.R         = r_q;

`ifdef MOD_ADD_RANGE_CHECK_EN
    logic rerr_q, rerr_d;
    assign bus.range_err = rerr_q & (state_q == DONE);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        s_d     = s_q;
        d_d     = d_q;
        r_d     = r_q;
        c_d     = c_q;
        bw_d    = bw_q;
`ifdef MOD_ADD_RANGE_CHECK_EN
        rerr_d  = rerr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    n_d     = bus.N;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    bw_d    = 1'b0;
                    state_d = CALC;
`ifdef MOD_ADD_RANGE_CHECK_EN
                    rerr_d  = (bus.A >= bus.N) | (bus.B >= bus.N)
                            | (bus.N == '0);
`endif
                end
            end
            CALC: begin
                a_d  = a_q >> DIGIT;
                b_d  = b_q >> DIGIT;
                n_d  = n_q >> DIGIT;
                s_d  = s_nx;
                d_d  = d_nx;
                c_d  = sum_k[DIGIT];
                bw_d = dif_k[DIGIT];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    // Reduce iff the WIDTH+1-bit sum reached N.
                    r_d     = (sum_k[DIGIT] | ~dif_k[DIGIT]) ? d_nx : s_nx;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            bw_q    <= 1'b0;
`ifdef MOD_ADD_RANGE_CHECK_EN
            rerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            s_q     <= s_d;
            d_q     <= d_d;
            r_q     <= r_d;
            c_q     <= c_d;
            bw_q    <= bw_d;
`ifdef MOD_ADD_RANGE_CHECK_EN
            rerr_q  <= rerr_d;
`endif
        end
    end
endmodule
